// File: rtl/led_mux_pkg.sv
// Shared types and the wrapping first-valid search for the LED mux scheduler.
// The search spans MAX_REQ slots; masks are zero-padded so wrapping at MAX_REQ matches wrapping at NUM_REQ.
package led_mux_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } state_t;

  // One-hot of the first set bit of mask at or after start, wrapping past MAX_REQ-1.
  function automatic logic [MAX_REQ-1:0] next_valid(input logic [MAX_REQ-1:0] mask,
                                                    input logic [IDX_W-1:0]   start);
    logic [MAX_REQ-1:0] pick;
    logic [IDX_W-1:0]   idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = start + IDX_W'(k);
      if (!found && mask[idx]) begin
        pick[idx] = 1'b1;
        found     = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/led_mux_scheduler_if.sv
// Requester-side inputs and LED/grant outputs of the LED mux scheduler.
interface led_mux_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned LED_W   = 4
);
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*LED_W-1:0] req_pattern;
  logic [LED_W-1:0]         led_n;
  logic [NUM_REQ-1:0]       grant;
  logic                     slot_done;

  modport master (
    output req_valid, req_pattern,
    input  led_n, grant, slot_done
  );

  modport slave (
    input  req_valid, req_pattern,
    output led_n, grant, slot_done
  );
endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first valid requester at or after start, wrapping.
module rr_pick
  import led_mux_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [IDX_W-1:0]   start,
  output logic [NUM_REQ-1:0] pick_c,
  output logic               found_c
);
  logic [MAX_REQ-1:0] full_c;

  assign full_c  = next_valid(MAX_REQ'(valid), start);
  assign pick_c  = full_c[NUM_REQ-1:0];
  assign found_c = |full_c;
endmodule

// File: rtl/led_mux_scheduler.sv
// Round-robin time-slicing of the board LEDs among status sources, with fixed dwell per grant.
// Optional idle heartbeat on led_n[0] when LED_MUX_BLINK_EN is defined.
module led_mux_scheduler
  import led_mux_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned LED_W        = 4,
  parameter int unsigned DWELL_CYCLES = 50_000_000,
  parameter int unsigned CNT_W        = 26
) (
  input logic                clk,
  input logic                reset,
  led_mux_scheduler_if.slave bus
);

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [LED_W-1:0]   led_q, led_d;
  logic               slot_done_q, slot_done_d;

  logic [NUM_REQ-1:0] pick_c;
  logic               found_c;
  logic [IDX_W-1:0]   pick_idx_c;
  logic [IDX_W-1:0]   rr_next_c;
  logic               expired_c;
  logic               dropped_c;
  logic [LED_W-1:0]   led_pat_c;
  logic [LED_W-1:0]   idle_led_c;

  // rr_q always holds owner+1 (wrapped) while showing, so one start serves both IDLE and SHOW.
  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid   (bus.req_valid),
    .start   (rr_q),
    .pick_c  (pick_c),
    .found_c (found_c)
  );

  always_comb begin : pick_encode
    pick_idx_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_c[i]) pick_idx_c = IDX_W'(i);
    end
    rr_next_c = (pick_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx_c + IDX_W'(1);
  end

  assign expired_c = (cnt_q == CNT_W'(DWELL_CYCLES - 1));
  assign dropped_c = ~|(bus.req_valid & grant_q);

  always_comb begin : next_state
    state_d     = state_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    rr_d        = rr_q;
    slot_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (found_c) begin
          state_d = SHOW;
          grant_d = pick_c;
          cnt_d   = '0;
          rr_d    = rr_next_c;
        end
      end
      SHOW: begin
        if (expired_c || dropped_c) begin
          slot_done_d = expired_c;
          cnt_d       = '0;
          if (found_c) begin
            grant_d = pick_c;
            rr_d    = rr_next_c;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        cnt_d   = '0;
      end
    endcase
  end

`ifdef LED_MUX_BLINK_EN
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             blink_q, blink_d;

  // Heartbeat restarts (off) on every IDLE entry and toggles once per dwell period while idle.
  always_comb begin : blink_next
    blink_cnt_d = '0;
    blink_d     = 1'b1;
    if (state_q == IDLE && state_d == IDLE) begin
      if (blink_cnt_q == CNT_W'(DWELL_CYCLES - 1)) begin
        blink_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CNT_W'(1);
        blink_d     = blink_q;
      end
    end
    idle_led_c    = '1;
    idle_led_c[0] = blink_d;
  end

  always_ff @(posedge clk) begin : blink_regs
    if (reset) begin
      blink_cnt_q <= '0;
      blink_q     <= 1'b1;
    end else begin
      blink_cnt_q <= blink_cnt_d;
      blink_q     <= blink_d;
    end
  end
`else
  assign idle_led_c = '1;
`endif

  // LED follows the next owner's live pattern so grant and led_n move on the same edge.
  always_comb begin : led_next
    led_pat_c = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant_d[i]) led_pat_c = led_pat_c | bus.req_pattern[i*LED_W +: LED_W];
    end
    led_d = (|grant_d) ? ~led_pat_c : idle_led_c;
  end

  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      cnt_q       <= '0;
      rr_q        <= '0;
      led_q       <= '1;
      slot_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      rr_q        <= rr_d;
      led_q       <= led_d;
      slot_done_q <= slot_done_d;
    end
  end

  assign bus.led_n     = led_q;
  assign bus.grant     = grant_q;
  assign bus.slot_done = slot_done_q;

endmodule

// File: tb/tb_led_mux_scheduler.sv
// Scenario bench for led_mux_scheduler with NUM_REQ=4, LED_W=4, DWELL_CYCLES=8.
module tb_led_mux_scheduler;

  typedef struct packed {
    logic [3:0] grant;
    logic [3:0] led;
    logic       sd;
  } exp_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  exp_t exp_q[$];

  led_mux_scheduler_if #(.NUM_REQ(4), .LED_W(4)) bus ();

  led_mux_scheduler #(
    .NUM_REQ(4), .LED_W(4), .DWELL_CYCLES(8), .CNT_W(4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    reset = 1'b1;
    bus.req_valid   = 4'b1111;
    bus.req_pattern = 16'h5CA3;
    for (int k = 1; k <= 3; k++) begin
      exp_q.push_back('{grant: 4'b0000, led: 4'hF, sd: 1'b0});
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_alternate();
    exp_t e, o;
    bus.req_valid   = 4'b0101;
    bus.req_pattern = 16'h5CA3;
    reset = 1'b0;
    for (int k = 1; k <= 33; k++) begin
      e.grant = (((k - 1) / 8) % 2 == 0) ? 4'b0001 : 4'b0100;
      e.led   = (((k - 1) / 8) % 2 == 0) ? 4'hC : 4'h3;
      e.sd    = (k > 1) && ((k - 1) % 8 == 0);
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL alternate k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_single();
    exp_t e, o;
    do_reset();
    bus.req_valid = 4'b0010;
    for (int k = 1; k <= 20; k++) begin
      bus.req_pattern = (k >= 12) ? 16'h00F0 : 16'h0060;
      e.grant = 4'b0010;
      e.led   = (k >= 12) ? 4'h0 : 4'h9;
      e.sd    = (k == 9) || (k == 17);
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL single k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t e, o;
    do_reset();
    bus.req_pattern = 16'h9C00;
    for (int k = 1; k <= 14; k++) begin
      if (k <= 2)      bus.req_valid = 4'b0100;
      else if (k <= 4) bus.req_valid = 4'b1100;
      else             bus.req_valid = 4'b1000;
      e.grant = (k <= 4) ? 4'b0100 : 4'b1000;
      e.led   = (k <= 4) ? 4'h3 : 4'h6;
      e.sd    = (k == 13);
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL preempt k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_expiry_drop();
    exp_t e, o;
    do_reset();
    bus.req_pattern = 16'h0021;
    for (int k = 1; k <= 10; k++) begin
      bus.req_valid = (k <= 8) ? 4'b0011 : 4'b0010;
      e.grant = (k <= 8) ? 4'b0001 : 4'b0010;
      e.led   = (k <= 8) ? 4'hE : 4'hD;
      e.sd    = (k == 9);
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL expiry_drop k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_idle_drop();
    exp_t e, o;
    do_reset();
    bus.req_pattern = 16'h9CA5;
    for (int k = 1; k <= 24; k++) begin
      if (k <= 3)       bus.req_valid = 4'b1111;
      else if (k <= 23) bus.req_valid = 4'b0000;
      else              bus.req_valid = 4'b1001;
      if (k <= 3) begin
        e.grant = 4'b0001;
        e.led   = 4'hA;
      end else if (k <= 23) begin
        e.grant = 4'b0000;
        e.led   = 4'hF;
`ifdef LED_MUX_BLINK_EN
        e.led[0] = (((k - 4) / 8) % 2 == 0);
`endif
      end else begin
        e.grant = 4'b1000;
        e.led   = 4'h6;
      end
      e.sd = 1'b0;
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL idle_drop k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    do_reset();
    bus.req_valid   = 4'b1111;
    bus.req_pattern = 16'h5CA3;
    for (int k = 1; k <= 17; k++) begin
      reset = (k == 15);
      if (k <= 8)       e = '{grant: 4'b0001, led: 4'hC, sd: 1'b0};
      else if (k <= 14) e = '{grant: 4'b0010, led: 4'h5, sd: (k == 9)};
      else if (k == 15) e = '{grant: 4'b0000, led: 4'hF, sd: 1'b0};
      else              e = '{grant: 4'b0001, led: 4'hC, sd: 1'b0};
      exp_q.push_back(e);
      @(posedge clk); #1;
      o = {bus.grant, bus.led_n, bus.slot_done};
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset_mid k=%0d: got grant=%b led_n=%h slot_done=%b, want grant=%b led_n=%h slot_done=%b",
                 k, o.grant, o.led, o.sd, e.grant, e.led, e.sd);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.req_valid   = '0;
    bus.req_pattern = '0;
    test_reset();
    test_alternate();
    test_single();
    test_preempt();
    test_expiry_drop();
    test_idle_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
